// File: rtl/fifo_split_pkg.sv
// rtl/fifo_split_pkg.sv - mode encoding and unit-select helpers for the FIFO word splitter
package fifo_split_pkg;

  localparam logic MODE_BASE  = 1'b0;
  localparam logic MODE_FLASH = 1'b1;
  localparam int   MAX_DW     = 256;

  function automatic int unsigned calc_nb(input int unsigned dw, input int unsigned bw);
    return dw / bw;
  endfunction

  function automatic int unsigned calc_iw(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  // Unit idx moved down to bit 0; the caller keeps only the low BW bits.
  function automatic logic [MAX_DW-1:0] slice(input logic [MAX_DW-1:0] word,
                                              input int unsigned idx,
                                              input int unsigned dw,
                                              input int unsigned bw,
                                              input bit msb_first);
    int unsigned sh;
    sh = msb_first ? (dw - bw * (idx + 1)) : (bw * idx);
    return word >> sh;
  endfunction

endpackage

// File: rtl/fprog_edge_sync.sv
// rtl/fprog_edge_sync.sv - 3-stage f_prog synchroniser with rise/fall detection
module fprog_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic f_prog_i,
  output logic mode_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] frnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frnt_q <= '0;
    else        frnt_q <= {frnt_q[1:0], f_prog_i};
  end

  // frnt_q[0] is the metastability catcher; mode and edges come from the settled stages.
  assign mode_o = frnt_q[1];
  assign rise_o = (frnt_q[2:1] == 2'b01);
  assign fall_o = (frnt_q[2:1] == 2'b10);

endmodule

// File: rtl/fifo_word_splitter.sv
// rtl/fifo_word_splitter.sv - FWFT FIFO reader splitting words into flash units or passing whole base words
module fifo_word_splitter
  import fifo_split_pkg::*;
#(
  parameter  int DW           = 16,
  parameter  int BW           = 8,
  parameter  int MSB_FIRST    = 1,
  parameter  int DROP_PARTIAL = 1,
  parameter  int CW           = 16,
  localparam int NB           = calc_nb(DW, BW),
  localparam int IW           = calc_iw(NB)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_prog,
  input  logic [DW-1:0] d_fifo,
  input  logic          fifo_empty,
  output logic          rd_fifo,
  input  logic          rd_flash,
  output logic [BW-1:0] o_flash,
  output logic          o_flash_vld,
  input  logic          rd_base,
  output logic [DW-1:0] o_base,
  output logic          o_base_vld,
  output logic [IW-1:0] byte_idx,
  output logic [CW-1:0] word_cnt,
  output logic          underrun,
  input  logic          clr_err
);

  logic mode, rise, fall, mode_edge;
  logic ready, flash_req, base_req, err_set, last_unit;
  logic [BW-1:0] unit;

  logic [IW-1:0] idx_q, idx_d;
  logic          rd_fifo_q, rd_fifo_d;
  logic [BW-1:0] o_flash_q, o_flash_d;
  logic          o_flash_vld_q, o_flash_vld_d;
  logic [DW-1:0] o_base_q, o_base_d;
  logic          o_base_vld_q, o_base_vld_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          underrun_q, underrun_d;

  fprog_edge_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .f_prog_i (f_prog),
    .mode_o   (mode),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  // While rd_fifo_q is high the FIFO head still shows the word being popped.
  assign mode_edge = rise | fall;
  assign ready     = !fifo_empty && !rd_fifo_q;
  assign flash_req = !mode_edge && (mode == MODE_FLASH) && rd_flash;
  assign base_req  = !mode_edge && (mode == MODE_BASE) && rd_base;
  assign err_set   = (flash_req || base_req) && fifo_empty;
  assign last_unit = (idx_q == IW'(NB - 1));
  assign unit      = BW'(slice(MAX_DW'(d_fifo), 32'(idx_q), DW, BW, MSB_FIRST != 0));

  always_comb begin
    idx_d         = idx_q;
    rd_fifo_d     = 1'b0;
    o_flash_d     = o_flash_q;
    o_flash_vld_d = 1'b0;
    o_base_d      = o_base_q;
    o_base_vld_d  = 1'b0;
    word_cnt_d    = word_cnt_q;
    underrun_d    = err_set ? 1'b1 : (clr_err ? 1'b0 : underrun_q);
    if (mode_edge) begin
      idx_d     = '0;
      rd_fifo_d = (DROP_PARTIAL != 0) && (idx_q != '0) && !fifo_empty;
      if (rise) word_cnt_d = '0;
    end else if (flash_req && ready) begin
      o_flash_d     = unit;
      o_flash_vld_d = 1'b1;
      if (last_unit) begin
        idx_d      = '0;
        rd_fifo_d  = 1'b1;
        word_cnt_d = word_cnt_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (base_req && ready) begin
      o_base_d     = d_fifo;
      o_base_vld_d = 1'b1;
      rd_fifo_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      rd_fifo_q     <= 1'b0;
      o_flash_q     <= '0;
      o_flash_vld_q <= 1'b0;
      o_base_q      <= '0;
      o_base_vld_q  <= 1'b0;
      word_cnt_q    <= '0;
      underrun_q    <= 1'b0;
    end else begin
      idx_q         <= idx_d;
      rd_fifo_q     <= rd_fifo_d;
      o_flash_q     <= o_flash_d;
      o_flash_vld_q <= o_flash_vld_d;
      o_base_q      <= o_base_d;
      o_base_vld_q  <= o_base_vld_d;
      word_cnt_q    <= word_cnt_d;
      underrun_q    <= underrun_d;
    end
  end

  assign rd_fifo     = rd_fifo_q;
  assign o_flash     = o_flash_q;
  assign o_flash_vld = o_flash_vld_q;
  assign o_base      = o_base_q;
  assign o_base_vld  = o_base_vld_q;
  assign byte_idx    = idx_q;
  assign word_cnt    = word_cnt_q;
  assign underrun    = underrun_q;

endmodule
